// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
//
// Runs one game round at a time, upstream of the ROUND OVER renderer.
// It tracks each player's remaining green blocks, counts down a round timer,
// and holds the end screen for a fixed time before returning to idle.
// While round_over is high the two block counts are frozen, so the renderer
// can sample them on any cycle (0 = red/loser, nonzero = green).
//
// Build option:
//   ROUND_TIMEOUT_EN  when defined, timer expiry also ends the round.
//                     When undefined, seconds_left still counts down and
//                     saturates at 0, but only block depletion ends a round.
//
// Parameters:
//   TICK_CYCLES    basys3_clk cycles per one-second tick
//   ROUND_SECONDS  round length in seconds (1..63)
//   HOLD_SECONDS   end-screen hold time in seconds (1..15)
//
// Ports:
//   basys3_clk            in   system clock
//   reset_n               in   asynchronous active-low reset
//   start                 in   pulse, begins a round from IDLE
//   hit_p1 / hit_p2       in   pulse, player lost one green block
//   green_block_count_p1  out  player 1 remaining blocks (2 bits)
//   green_block_count_p2  out  player 2 remaining blocks (2 bits)
//   round_over            out  high while in OVER
//   playing               out  high while in PLAY
//   seconds_left          out  remaining round seconds (6 bits)
//   round_num             out  completed-round counter, wraps 15 -> 0
// -----------------------------------------------------------------------------
module round_controller #(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int ROUND_SECONDS = 30,
  parameter int HOLD_SECONDS  = 3
) (
  input  logic       basys3_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [1:0] green_block_count_p1,
  output logic [1:0] green_block_count_p2,
  output logic       round_over,
  output logic       playing,
  output logic [5:0] seconds_left,
  output logic [3:0] round_num
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0]   TICK_ZERO = TW'(0);
  localparam logic [TW-1:0]   TICK_ONE  = TW'(1);
  localparam logic [5:0]      SEC_LOAD  = 6'(ROUND_SECONDS);
  localparam logic [3:0]      HOLD_LOAD = 4'(HOLD_SECONDS);

`ifdef ROUND_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  function automatic logic [1:0] dec_sat2(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : (v - 2'd1);
  endfunction

  function automatic logic [5:0] dec_sat6(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : (v - 6'd1);
  endfunction

  logic [1:0]    state_r,   state_nxt_s;
  logic [1:0]    cnt_p1_r,  cnt_p1_nxt_s;
  logic [1:0]    cnt_p2_r,  cnt_p2_nxt_s;
  logic [5:0]    sec_r,     sec_nxt_s;
  logic [3:0]    round_r,   round_nxt_s;
  logic [3:0]    hold_r,    hold_nxt_s;
  logic [TW-1:0] tick_r,    tick_nxt_s;
  logic          playing_r;
  logic          over_r;
  logic          tick_wrap_s;

  // Next-state and datapath updates for the round FSM.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_p1_nxt_s = cnt_p1_r;
    cnt_p2_nxt_s = cnt_p2_r;
    sec_nxt_s    = sec_r;
    round_nxt_s  = round_r;
    hold_nxt_s   = hold_r;
    tick_nxt_s   = tick_r;
    tick_wrap_s  = (tick_r == TICK_LAST);

    case (state_r)
      ST_IDLE: begin
        cnt_p1_nxt_s = 2'd3;
        cnt_p2_nxt_s = 2'd3;
        sec_nxt_s    = SEC_LOAD;
        tick_nxt_s   = TICK_ZERO;
        hold_nxt_s   = 4'd0;
        if (start) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_PLAY: begin
        // End condition looks at the registered values, so OVER is entered
        // the cycle after the terminating update; counts are left untouched
        // on that edge, which is what freezes them.
        if ((cnt_p1_r == 2'd0) || (cnt_p2_r == 2'd0) ||
            (TIMEOUT_EN && (sec_r == 6'd0))) begin
          state_nxt_s = ST_OVER;
          round_nxt_s = round_r + 4'd1;
          hold_nxt_s  = HOLD_LOAD;
          tick_nxt_s  = TICK_ZERO;
        end else begin
          state_nxt_s = ST_PLAY;
          if (tick_wrap_s) begin
            tick_nxt_s = TICK_ZERO;
            sec_nxt_s  = dec_sat6(sec_r);
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
            sec_nxt_s  = sec_r;
          end
          if (hit_p1) begin
            cnt_p1_nxt_s = dec_sat2(cnt_p1_r);
          end else begin
            cnt_p1_nxt_s = cnt_p1_r;
          end
          if (hit_p2) begin
            cnt_p2_nxt_s = dec_sat2(cnt_p2_r);
          end else begin
            cnt_p2_nxt_s = cnt_p2_r;
          end
        end
      end

      ST_OVER: begin
        if (hold_r == 4'd0) begin
          state_nxt_s  = ST_IDLE;
          cnt_p1_nxt_s = 2'd3;
          cnt_p2_nxt_s = 2'd3;
          sec_nxt_s    = SEC_LOAD;
          tick_nxt_s   = TICK_ZERO;
        end else begin
          state_nxt_s = ST_OVER;
          if (tick_wrap_s) begin
            tick_nxt_s = TICK_ZERO;
            hold_nxt_s = hold_r - 4'd1;
          end else begin
            tick_nxt_s = tick_r + TICK_ONE;
            hold_nxt_s = hold_r;
          end
        end
      end

      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_p1_nxt_s = 2'd3;
        cnt_p2_nxt_s = 2'd3;
        sec_nxt_s    = SEC_LOAD;
        tick_nxt_s   = TICK_ZERO;
        hold_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and output registers; status flags are decoded from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge basys3_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      cnt_p1_r  <= 2'd3;
      cnt_p2_r  <= 2'd3;
      sec_r     <= SEC_LOAD;
      round_r   <= 4'd0;
      hold_r    <= 4'd0;
      tick_r    <= TICK_ZERO;
      playing_r <= 1'b0;
      over_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_p1_r  <= cnt_p1_nxt_s;
      cnt_p2_r  <= cnt_p2_nxt_s;
      sec_r     <= sec_nxt_s;
      round_r   <= round_nxt_s;
      hold_r    <= hold_nxt_s;
      tick_r    <= tick_nxt_s;
      playing_r <= (state_nxt_s == ST_PLAY);
      over_r    <= (state_nxt_s == ST_OVER);
    end
  end

  assign green_block_count_p1 = cnt_p1_r;
  assign green_block_count_p2 = cnt_p2_r;
  assign round_over           = over_r;
  assign playing              = playing_r;
  assign seconds_left         = sec_r;
  assign round_num            = round_r;

endmodule
